// File: rtl/imm_pkg.sv
// Shared types for the ID->EX immediate-extension pipeline: extension modes and skid-buffer states.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO   = 2'd0,
        IMM_SIGN   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_t;

    // EMPTY: M and S invalid; ONE: only M valid; TWO: M and S valid.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender (zero, sign, upper, branch offset).
// IMM_BRANCH_SHIFT_EN defined: mode 3 is sign-extend then shift left by 2; otherwise mode 3 equals mode 1.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  i_imm,
    input  imm_mode_t        i_mode,
    output logic [OUT_W-1:0] o_ext
);

    logic [OUT_W-1:0] w_sext;

    assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};

    always_comb begin
        // NOTE: o_ext gets a value before the case so no path leaves it unassigned and no latch is inferred.
        o_ext = w_sext;
        case (i_mode)
            IMM_ZERO:   o_ext = {{(OUT_W-IN_W){1'b0}}, i_imm};
            IMM_SIGN:   o_ext = w_sext;
            IMM_UPPER:  o_ext = {i_imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_BRANCH_SHIFT_EN
            IMM_BRANCH: o_ext = w_sext << 2;
`else
            IMM_BRANCH: o_ext = w_sext;
`endif
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a two-entry skid buffer and synchronous flush (ID->EX path).
// IMM_BRANCH_SHIFT_EN selects branch-offset behaviour for mode 3 inside imm_ext_core. Requires OUT_W >= IN_W+2.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [OUT_W-1:0] r_m_data;
    logic [TAG_W-1:0] r_m_tag;
    logic [OUT_W-1:0] r_s_data;
    logic [TAG_W-1:0] r_s_tag;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_m_in;
    logic             w_load_m_skid;
    logic             w_load_s;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm  (in_imm),
        .i_mode (imm_mode_t'(in_mode)),
        .o_ext  (w_ext)
    );

    // Both handshake outputs decode the state register only, so in_ready never depends on out_ready.
    assign out_valid = (r_state != SKID_EMPTY);
    assign in_ready  = (r_state != SKID_TWO);
    assign out_data  = r_m_data;
    assign out_tag   = r_m_tag;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        if (flush) begin
            w_state_nxt = SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = SKID_ONE;
                        w_load_m_in = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && !w_pop) begin
                        w_state_nxt = SKID_TWO;
                        w_load_s    = 1'b1;
                    end else if (w_accept && w_pop) begin
                        w_load_m_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (w_pop) begin
                        w_state_nxt   = SKID_ONE;
                        w_load_m_skid = 1'b1;
                    end
                end
                default: w_state_nxt = SKID_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: payload registers are reset too, because out_data/out_tag must read 0 and S must be clear after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_data <= '0;
            r_m_tag  <= '0;
            r_s_data <= '0;
            r_s_tag  <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_data <= w_ext;
                r_m_tag  <= in_tag;
            end else if (w_load_m_skid) begin
                r_m_data <= r_s_data;
                r_m_tag  <= r_s_tag;
            end
            if (w_load_s) begin
                r_s_data <= w_ext;
                r_s_tag  <= in_tag;
            end
        end
    end

endmodule
